// File: rtl/bs_packet_dispatcher.sv
// bs_packet_dispatcher
// Pops 256-bit board-switch packets from an FWFT FIFO and routes each one,
// by its BS_ID header byte, to the matrix-multiplier channel, Aurora lane 0,
// Aurora lane 1, or all three for broadcast. Packets with an unknown BS_ID or
// an out-of-range VALID_PACKET_BYTES are popped, discarded and counted.
//
// Ports:
//   clk_200MHz, peripheral_aresetn   clock / async active-low reset
//   fifo_dout, fifo_not_empty        FIFO head word and its valid flag
//   fifo_rd_en                       pop the head word this cycle
//   m_{xmult,aur0,aur1}_tdata/tvalid/tready   three stream outputs
//   drop_count                       saturating count of dropped packets

// One output channel: a single pending bit, which is also the channel's tvalid.
module bs_dispatch_lane (
  input  logic clk_200MHz,
  input  logic peripheral_aresetn,
  input  logic load,      // a packet is being popped this cycle
  input  logic load_bit,  // this channel is a destination of that packet
  input  logic tready,
  output logic tvalid,
  output logic left       // copy still outstanding after this cycle
);
  logic pend_q;

  // A load only happens once every outstanding copy has been accepted, so it
  // may simply overwrite the bit.
  always_ff @(posedge clk_200MHz or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn)    pend_q <= 1'b0;
    else if (load)              pend_q <= load_bit;
    else if (pend_q && tready)  pend_q <= 1'b0;
  end

  assign tvalid = pend_q;
  assign left   = pend_q & ~tready;
endmodule

module bs_packet_dispatcher #(
  parameter int         DATA_WIDTH = 256,
  parameter logic [7:0] ID_XMULT   = 8'h00,
  parameter logic [7:0] ID_AUROR_0 = 8'h03,
  parameter logic [7:0] ID_AUROR_1 = 8'h02,
  parameter logic [7:0] ID_BROAD   = 8'hFF,
  parameter int         MAX_BYTES  = 24
) (
  input  logic                  clk_200MHz,
  input  logic                  peripheral_aresetn,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_not_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_xmult_tdata,
  output logic                  m_xmult_tvalid,
  input  logic                  m_xmult_tready,
  output logic [DATA_WIDTH-1:0] m_aur0_tdata,
  output logic                  m_aur0_tvalid,
  input  logic                  m_aur0_tready,
  output logic [DATA_WIDTH-1:0] m_aur1_tdata,
  output logic                  m_aur1_tvalid,
  input  logic                  m_aur1_tready,
  output logic [15:0]           drop_count
);
  // Lane order matches the destination mask {xmult, aur0, aur1}.
  localparam int NUM_LANES = 3;

  typedef enum logic {IDLE, HOLD} state_e;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  hold_q;
  logic [NUM_LANES-1:0]   mask, pend, left, tready_v;
  logic [7:0]             bs_id;
  logic [15:0]            pkt_bytes;
  logic                   legal, pop;

  assign bs_id     = fifo_dout[DATA_WIDTH-1  -: 8];
  assign pkt_bytes = fifo_dout[DATA_WIDTH-49 -: 16];

  always_comb begin
    mask = '0;
    if      (bs_id == ID_XMULT)   mask = 3'b100;
    else if (bs_id == ID_AUROR_0) mask = 3'b010;
    else if (bs_id == ID_AUROR_1) mask = 3'b001;
    else if (bs_id == ID_BROAD)   mask = 3'b111;
  end

  assign legal = (mask != '0) && (pkt_bytes != 16'd0) &&
                 (pkt_bytes <= 16'(MAX_BYTES));

  // Pop as soon as nothing would remain pending after this edge, so the next
  // packet follows the last accepted copy with no bubble. Reset gates the pop
  // because the FIFO sees this combinationally.
  assign pop = peripheral_aresetn & fifo_not_empty &
               ((state_q == IDLE) | (left == '0));
  assign fifo_rd_en = pop;

  assign tready_v = {m_xmult_tready, m_aur0_tready, m_aur1_tready};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    bs_dispatch_lane u_lane (
      .clk_200MHz         (clk_200MHz),
      .peripheral_aresetn (peripheral_aresetn),
      .load               (pop),
      .load_bit           (mask[i] & legal),
      .tready             (tready_v[i]),
      .tvalid             (pend[i]),
      .left               (left[i])
    );
  end

  assign {m_xmult_tvalid, m_aur0_tvalid, m_aur1_tvalid} = pend;
  assign m_xmult_tdata = hold_q;
  assign m_aur0_tdata  = hold_q;
  assign m_aur1_tdata  = hold_q;

  always_comb begin
    state_d = state_q;
    if (pop)                state_d = legal ? HOLD : IDLE;
    else if (left == '0)    state_d = IDLE;
  end

  always_ff @(posedge clk_200MHz or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      drop_count <= '0;
    end else begin
      state_q <= state_d;
      if (pop && legal) hold_q <= fifo_dout;
      if (pop && !legal && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_bs_packet_dispatcher.sv
module tb_bs_packet_dispatcher;
  logic         clk_200MHz = 1'b0;
  logic         peripheral_aresetn;
  logic [255:0] fifo_dout;
  logic         fifo_not_empty, fifo_rd_en;
  logic [255:0] m_xmult_tdata, m_aur0_tdata, m_aur1_tdata;
  logic         m_xmult_tvalid, m_aur0_tvalid, m_aur1_tvalid;
  logic         m_xmult_tready, m_aur0_tready, m_aur1_tready;
  logic [15:0]  drop_count;

  always #5 clk_200MHz = ~clk_200MHz;

  bs_packet_dispatcher dut (
    .clk_200MHz(clk_200MHz), .peripheral_aresetn(peripheral_aresetn),
    .fifo_dout(fifo_dout), .fifo_not_empty(fifo_not_empty), .fifo_rd_en(fifo_rd_en),
    .m_xmult_tdata(m_xmult_tdata), .m_xmult_tvalid(m_xmult_tvalid), .m_xmult_tready(m_xmult_tready),
    .m_aur0_tdata(m_aur0_tdata), .m_aur0_tvalid(m_aur0_tvalid), .m_aur0_tready(m_aur0_tready),
    .m_aur1_tdata(m_aur1_tdata), .m_aur1_tvalid(m_aur1_tvalid), .m_aur1_tready(m_aur1_tready),
    .drop_count(drop_count)
  );

  // Channel index in the bench: 0 = xmult, 1 = aur0, 2 = aur1.
  int           total = 0, bad = 0, cyc = 0, viol = 0, exp_drops = 0;
  logic [255:0] fifo_q[$];
  logic [255:0] exp_q[3][$];
  logic [255:0] got_q[3][$];
  int           acc_cyc[3][$];
  int           pop_cyc[$];
  int           tv_cnt[3];
  logic         stall[3];
  logic [255:0] stall_d[3];

  function automatic void refresh();
    fifo_not_empty = (fifo_q.size() != 0);
    fifo_dout      = fifo_not_empty ? fifo_q[0] : '0;
  endfunction

  task automatic set_ready(input logic [2:0] r);
    {m_aur1_tready, m_aur0_tready, m_xmult_tready} = r;
  endtask

  // Advance one clock. Observes handshakes at the negedge (for the coming
  // edge), then models the FIFO pop just after the edge.
  task automatic tick();
    logic [2:0]   tv, tr;
    logic [255:0] td[3];
    logic         p;
    @(negedge clk_200MHz);
    tv = {m_aur1_tvalid, m_aur0_tvalid, m_xmult_tvalid};
    tr = {m_aur1_tready, m_aur0_tready, m_xmult_tready};
    td[0] = m_xmult_tdata; td[1] = m_aur0_tdata; td[2] = m_aur1_tdata;
    p = fifo_rd_en;
    if (p) pop_cyc.push_back(cyc + 1);
    if (fifo_rd_en && !fifo_not_empty) viol++;
    for (int ch = 0; ch < 3; ch++) begin
      if (tv[ch]) tv_cnt[ch]++;
      if (stall[ch] && (!tv[ch] || td[ch] !== stall_d[ch])) viol++;
      if (tv[ch] && tr[ch]) begin
        got_q[ch].push_back(td[ch]);
        acc_cyc[ch].push_back(cyc + 1);
      end
      stall[ch]   = tv[ch] & ~tr[ch];
      stall_d[ch] = td[ch];
    end
    @(posedge clk_200MHz);
    cyc++;
    #1;
    if (p) begin
      void'(fifo_q.pop_front());
      refresh();
    end
    #1;
  endtask

  // Queue a packet and predict its fate from the header rules.
  task automatic send(input logic [7:0] id, input logic [15:0] len,
                      input logic [15:0] pid, input bit rnd_msgs);
    logic [255:0] w;
    logic [2:0]   m;
    w = '0;
    w[255:248] = id;
    w[247:240] = 8'($urandom);
    w[239:224] = pid;
    w[223:208] = 16'($urandom);
    w[207:192] = len;
    for (int k = 0; k < 6; k++) w[32*k +: 32] = rnd_msgs ? 32'($urandom) : 32'd1;
    fifo_q.push_back(w);
    refresh();
    case (id)
      8'h00:   m = 3'b001;
      8'h03:   m = 3'b010;
      8'h02:   m = 3'b100;
      8'hFF:   m = 3'b111;
      default: m = 3'b000;
    endcase
    if (m != 0 && len >= 1 && len <= 24) begin
      for (int ch = 0; ch < 3; ch++) if (m[ch]) exp_q[ch].push_back(w);
    end else if (exp_drops < 65535) exp_drops++;
  endtask

  task automatic clear_logs();
    for (int ch = 0; ch < 3; ch++) begin
      exp_q[ch].delete(); got_q[ch].delete(); acc_cyc[ch].delete(); tv_cnt[ch] = 0;
    end
    pop_cyc.delete();
  endtask

  function automatic int sb_diff();
    int n = 0;
    for (int ch = 0; ch < 3; ch++) begin
      if (got_q[ch].size() != exp_q[ch].size()) n++;
      else for (int i = 0; i < got_q[ch].size(); i++) if (got_q[ch][i] !== exp_q[ch][i]) n++;
    end
    return n;
  endfunction

  task automatic drain(input int max, input bit rnd, output bit to);
    to = 1'b1;
    for (int i = 0; i < max; i++) begin
      if (fifo_q.size() == 0 && !m_xmult_tvalid && !m_aur0_tvalid && !m_aur1_tvalid) begin
        to = 1'b0;
        break;
      end
      if (rnd) set_ready(3'($urandom));
      tick();
    end
  endtask

  task automatic do_reset();
    peripheral_aresetn = 1'b0;
    for (int ch = 0; ch < 3; ch++) stall[ch] = 1'b0;
    fifo_q.delete(); refresh(); clear_logs(); exp_drops = 0;
    tick(); tick();
    peripheral_aresetn = 1'b1;
  endtask

  task automatic test_reset();
    bit to; int rel;
    set_ready(3'b111);
    for (int ch = 0; ch < 3; ch++) stall[ch] = 1'b0;
    peripheral_aresetn = 1'b1; #1; peripheral_aresetn = 1'b0;
    clear_logs();
    send(8'h02, 16'd24, 16'd7, 1'b1);
    tick(); tick();
    total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
    total++; if ({m_xmult_tvalid, m_aur0_tvalid, m_aur1_tvalid} !== 3'b000) begin bad++;
      $display("FAIL reset_tvalid: got %b want 000", {m_xmult_tvalid, m_aur0_tvalid, m_aur1_tvalid}); end
    total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL reset_drops: got %0d want 0", drop_count); end
    total++; if ((m_xmult_tdata | m_aur0_tdata | m_aur1_tdata) !== '0) begin bad++; $display("FAIL reset_tdata: got nonzero want 0"); end
    peripheral_aresetn = 1'b1;
    rel = cyc;
    #1;
    total++; if (fifo_rd_en !== 1'b1) begin bad++; $display("FAIL release_rd_en: got %b want 1", fifo_rd_en); end
    drain(20, 1'b0, to);
    total++; if (to || pop_cyc.size() != 1 || pop_cyc[0] != rel + 1) begin bad++;
      $display("FAIL release_first_pop: pops=%0d timeout=%0d want one pop at edge %0d", pop_cyc.size(), to, rel + 1); end
    total++; if (sb_diff() != 0) begin bad++; $display("FAIL release_sb: %0d diffs want 0", sb_diff()); end
  endtask

  task automatic test_single();
    bit to;
    clear_logs(); set_ready(3'b111);
    send(8'h02, 16'd24, 16'd0, 1'b0);
    drain(20, 1'b0, to);
    total++; if (to || pop_cyc.size() != 1) begin bad++; $display("FAIL single_pops: got %0d want 1", pop_cyc.size()); end
    total++; if (tv_cnt[2] != 1 || tv_cnt[0] != 0 || tv_cnt[1] != 0) begin bad++;
      $display("FAIL single_tvalid_cycles: got x=%0d a0=%0d a1=%0d want 0 0 1", tv_cnt[0], tv_cnt[1], tv_cnt[2]); end
    total++; if (acc_cyc[2].size() != 1 || pop_cyc.size() != 1 || acc_cyc[2][0] != pop_cyc[0] + 1) begin bad++;
      $display("FAIL single_latency: accepts=%0d want one, one edge after pop", acc_cyc[2].size()); end
    total++; if (sb_diff() != 0) begin bad++; $display("FAIL single_data: %0d diffs want 0", sb_diff()); end
  endtask

  task automatic test_streaming();
    bit to; int gaps = 0, order = 0;
    clear_logs(); set_ready(3'b111);
    for (int p = 0; p < 36; p++) send(8'h02, 16'd24, 16'(p), 1'b1);
    drain(100, 1'b0, to);
    total++; if (to || acc_cyc[2].size() != 36) begin bad++; $display("FAIL stream_count: got %0d want 36", acc_cyc[2].size()); end
    for (int i = 1; i < acc_cyc[2].size(); i++) if (acc_cyc[2][i] != acc_cyc[2][i-1] + 1) gaps++;
    for (int i = 0; i < got_q[2].size(); i++) if (got_q[2][i][239:224] != 16'(i)) order++;
    total++; if (gaps != 0) begin bad++; $display("FAIL stream_gaps: got %0d want 0", gaps); end
    total++; if (order != 0) begin bad++; $display("FAIL stream_order: got %0d out of order want 0", order); end
    total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL stream_drops: got %0d want 0", drop_count); end
    total++; if (sb_diff() != 0) begin bad++; $display("FAIL stream_sb: %0d diffs want 0", sb_diff()); end
  endtask

  task automatic test_broadcast();
    bit to; int n0;
    clear_logs(); set_ready(3'b101);   // aur0 stalled
    send(8'hFF, 16'd16, 16'd100, 1'b1);
    send(8'hFF, 16'd16, 16'd101, 1'b1);
    tick();
    n0 = (pop_cyc.size() > 0) ? pop_cyc[0] : -100;
    for (int i = 0; i < 5; i++) tick();
    set_ready(3'b111);
    drain(20, 1'b0, to);
    total++; if (to || acc_cyc[0].size() != 2 || acc_cyc[1].size() != 2 || acc_cyc[2].size() != 2) begin bad++;
      $display("FAIL bcast_copies: got %0d %0d %0d want 2 2 2", acc_cyc[0].size(), acc_cyc[1].size(), acc_cyc[2].size()); end
    else begin
      total++; if (acc_cyc[0][0] != n0 + 1 || acc_cyc[2][0] != n0 + 1) begin bad++;
        $display("FAIL bcast_fast_lanes: got %0d %0d want %0d", acc_cyc[0][0], acc_cyc[2][0], n0 + 1); end
      total++; if (acc_cyc[1][0] != n0 + 6) begin bad++; $display("FAIL bcast_slow_lane: got %0d want %0d", acc_cyc[1][0], n0 + 6); end
    end
    total++; if (pop_cyc.size() != 2 || pop_cyc[1] != n0 + 6) begin bad++;
      $display("FAIL bcast_second_pop: pops=%0d want second at edge %0d", pop_cyc.size(), n0 + 6); end
    total++; if (sb_diff() != 0) begin bad++; $display("FAIL bcast_sb: %0d diffs want 0", sb_diff()); end
  endtask

  task automatic test_back_to_back();
    bit to; int errs = 0;
    clear_logs(); set_ready(3'b111);
    for (int p = 0; p < 4; p++) send(8'hFF, 16'd4, 16'(200 + p), 1'b1);
    drain(20, 1'b0, to);
    if (pop_cyc.size() != 4) errs++;
    else for (int i = 0; i < 4; i++) begin
      if (pop_cyc[i] != pop_cyc[0] + i) errs++;
      for (int ch = 0; ch < 3; ch++)
        if (acc_cyc[ch].size() != 4 || acc_cyc[ch][i] != pop_cyc[i] + 1) errs++;
    end
    total++; if (to || errs != 0) begin bad++; $display("FAIL b2b_bcast_rate: got %0d timing errors want 0", errs); end
    total++; if (sb_diff() != 0) begin bad++; $display("FAIL b2b_sb: %0d diffs want 0", sb_diff()); end
  endtask

  task automatic test_drops();
    bit to; int gaps = 0;
    clear_logs(); set_ready(3'b111);
    send(8'h07, 16'd24, 16'd1, 1'b1);
    send(8'h00, 16'd0,  16'd2, 1'b1);
    send(8'h03, 16'd25, 16'd3, 1'b1);
    send(8'h03, 16'd8,  16'd4, 1'b1);
    drain(20, 1'b0, to);
    for (int i = 1; i < pop_cyc.size(); i++) if (pop_cyc[i] != pop_cyc[i-1] + 1) gaps++;
    total++; if (to || pop_cyc.size() != 4 || gaps != 0) begin bad++;
      $display("FAIL drop_pops: got %0d pops %0d gaps want 4 consecutive", pop_cyc.size(), gaps); end
    total++; if (drop_count !== 16'd3) begin bad++; $display("FAIL drop_count: got %0d want 3", drop_count); end
    total++; if (tv_cnt[0] != 0 || tv_cnt[2] != 0 || tv_cnt[1] != 1) begin bad++;
      $display("FAIL drop_tvalid: got %0d %0d %0d want 0 1 0", tv_cnt[0], tv_cnt[1], tv_cnt[2]); end
    total++; if (sb_diff() != 0) begin bad++; $display("FAIL drop_sb: %0d diffs want 0", sb_diff()); end
  endtask

  task automatic test_random();
    bit to; logic [7:0] id;
    clear_logs();
    for (int p = 0; p < 60; p++) begin
      case ($urandom_range(0, 4))
        0: id = 8'h00;  1: id = 8'h03;  2: id = 8'h02;  3: id = 8'hFF;
        default: id = 8'($urandom);
      endcase
      send(id, 16'($urandom_range(0, 28)), 16'(300 + p), 1'b1);
    end
    drain(3000, 1'b1, to);
    set_ready(3'b111);
    total++; if (to) begin bad++; $display("FAIL rand_timeout: fifo=%0d left want drained", fifo_q.size()); end
    total++; if (sb_diff() != 0) begin bad++; $display("FAIL rand_sb: %0d diffs want 0", sb_diff()); end
    total++; if (drop_count !== 16'(exp_drops)) begin bad++; $display("FAIL rand_drops: got %0d want %0d", drop_count, exp_drops); end
    total++; if (viol != 0) begin bad++; $display("FAIL rand_protocol: got %0d violations want 0", viol); end
  endtask

  task automatic test_mid_reset();
    bit seen = 1'b0;
    clear_logs(); set_ready(3'b110);   // xmult stalled
    send(8'h00, 16'd24, 16'd500, 1'b1);
    for (int i = 0; i < 10 && !seen; i++) begin tick(); seen = m_xmult_tvalid; end
    tick(); tick();
    total++; if (m_xmult_tvalid !== 1'b1) begin bad++; $display("FAIL midrst_held: got %b want 1", m_xmult_tvalid); end
    peripheral_aresetn = 1'b0;
    for (int ch = 0; ch < 3; ch++) stall[ch] = 1'b0;
    #1;
    total++; if (m_xmult_tvalid !== 1'b0) begin bad++; $display("FAIL midrst_drop: got %b want 0", m_xmult_tvalid); end
    tick(); tick();
    clear_logs(); exp_drops = 0;
    peripheral_aresetn = 1'b1;
    set_ready(3'b111);
    for (int i = 0; i < 10; i++) tick();
    total++; if (tv_cnt[0] != 0 || got_q[0].size() != 0) begin bad++;
      $display("FAIL midrst_resend: got %0d valid cycles want 0", tv_cnt[0]); end
  endtask

  task automatic test_saturation();
    bit to;
    do_reset();
    set_ready(3'b111);
    for (int i = 0; i < 65534; i++) send(8'h07, 16'd24, 16'(i), 1'b0);
    drain(70000, 1'b0, to);
    total++; if (to || drop_count !== 16'hFFFE) begin bad++; $display("FAIL sat_preload: got %0h want fffe", drop_count); end
    send(8'h55, 16'd4, 16'd0, 1'b0);
    send(8'h02, 16'd0, 16'd1, 1'b0);
    drain(20, 1'b0, to);
    total++; if (to || drop_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got %0h want ffff", drop_count); end
    total++; if (viol != 0) begin bad++; $display("FAIL final_protocol: got %0d violations want 0", viol); end
  endtask

  initial begin
    set_ready(3'b111);
    fifo_q.delete(); refresh();
    test_reset();
    test_single();
    test_streaming();
    test_broadcast();
    test_back_to_back();
    test_drops();
    test_random();
    test_mid_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
